// File: rtl/btn_pulse.sv
// btn_pulse: synchronizes and debounces a raw push-button level, then emits one
// registered single-cycle count-enable pulse per accepted press.
//
// Ports:
//   clk       in   single clock, all state updates on posedge
//   reset     in   asynchronous active-low reset
//   sw        in   raw asynchronous bouncing button level, 1 = pressed
//   x         out  registered one-cycle pulse per debounced press
//   sw_level  out  registered debounced button level, 1 = stably pressed
//
// Parameter DB_CYCLES (2..65535) is the number of consecutive stable
// synchronized samples counted in PRESS_CHK / REL_CHK before a level change
// is accepted.
module btn_pulse #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic x,
   output logic sw_level
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      PRESSED   = 2'd2,
      REL_CHK   = 2'd3
   } state_t;

   logic             s1;
   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer; only s2 is allowed to reach the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end
   end

   // Debounce FSM with registered pulse and level outputs.
   // x defaults low every cycle so it can only be high for the single cycle
   // after the PRESS_CHK -> PRESSED transition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         x        <= 1'b0;
         sw_level <= 1'b0;
      end else begin
         x <= 1'b0;
         case (state)
            IDLE: begin
               if (s2) begin
                  state <= PRESS_CHK;
                  cnt   <= '0;
               end
            end
            PRESS_CHK: begin
               if (!s2) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state    <= PRESSED;
                  x        <= 1'b1;
                  sw_level <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!s2) begin
                  state <= REL_CHK;
                  cnt   <= '0;
               end
            end
            REL_CHK: begin
               if (s2) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state    <= IDLE;
                  sw_level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               sw_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_pulse.sv
// Bench for btn_pulse (N = 4): directed scenarios plus randomized bouncing
// stimulus, compared every cycle against a run-length reference model, and a
// downstream BCD counter driven by x for the chained count check.
module tb_btn_pulse;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic reset;
   logic sw;
   logic x;
   logic sw_level;

   int checks = 0;
   int errors = 0;

   // Reference model: two-sample input delay, then the debounced level flips
   // once the delayed input has disagreed with it for N+1 consecutive edges.
   logic        m_s1, m_s2, m_level, m_x;
   int unsigned m_run;

   // Per-window observations.
   int  idx;
   int  obs_pulses;
   int  pulse_idx;
   int  fall_idx;
   int  rise_idx;
   logic prev_level;
   logic level_seen_high;

   logic [3:0] bcd;

   always #5 clk = ~clk;

   btn_pulse #(.DB_CYCLES(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw),
      .x        (x),
      .sw_level (sw_level)
   );

   // Downstream BCD counter stage enabled by x.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  bcd <= 4'd0;
      else if (x)  bcd <= (bcd == 4'd9) ? 4'd0 : 4'(bcd + 4'd1);
   end

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_x = 1'b0; m_run = 0;
   endtask

   task automatic model_edge(input logic v);
      m_x = 1'b0;
      if (m_s2 != m_level) begin
         m_run++;
         if (m_run == N + 1) begin
            m_level = ~m_level;
            m_run   = 0;
            m_x     = m_level;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = v;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic window_start();
      idx = 0; obs_pulses = 0; pulse_idx = -1; fall_idx = -1; rise_idx = -1;
      prev_level = sw_level; level_seen_high = 1'b0;
   endtask

   // Drive one cycle of sw, then check outputs against the model after the edge.
   task automatic step(input logic v);
      sw = v;
      @(posedge clk);
      model_edge(v);
      #1;
      check_bit("x", x, m_x);
      check_bit("sw_level", sw_level, m_level);
      if (x === 1'b1) begin
         obs_pulses++;
         pulse_idx = idx;
      end
      if (sw_level === 1'b1) level_seen_high = 1'b1;
      if (prev_level === 1'b1 && sw_level === 1'b0) fall_idx = idx;
      if (prev_level === 1'b0 && sw_level === 1'b1) rise_idx = idx;
      prev_level = sw_level;
      idx++;
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      sw    = 1'b0;
      reset = 1'b0;
      model_reset();
      #2;
      check_bit("reset_x", x, 1'b0);
      check_bit("reset_sw_level", sw_level, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      hold(1'b0, 5);

      // Clean press held 20 cycles: single pulse at E6, level high from E6.
      window_start();
      hold(1'b1, 20);
      check_int("clean_pulse_count", obs_pulses, 1);
      check_int("clean_pulse_edge", pulse_idx, 6);
      check_int("clean_level_rise_edge", rise_idx, 6);
      // Release: level falls at E6 of the release.
      window_start();
      hold(1'b0, 10);
      check_int("release_fall_edge", fall_idx, 6);
      check_int("release_pulse_count", obs_pulses, 0);

      // Bounce 1,0,1,0,1,0 then held: pulse 6 edges after final rise (idx 6).
      window_start();
      step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
      hold(1'b1, 15);
      check_int("bounce_pulse_count", obs_pulses, 1);
      check_int("bounce_pulse_edge", pulse_idx, 12);
      hold(1'b0, 10);

      // Short glitch of 3 cycles: no pulse, level never rises.
      window_start();
      hold(1'b1, 3);
      hold(1'b0, 12);
      check_int("glitch_pulse_count", obs_pulses, 0);
      check_bit("glitch_level_seen", level_seen_high, 1'b0);
      // Back in IDLE: a clean press still gives the pulse at E6.
      window_start();
      hold(1'b1, 10);
      check_int("post_glitch_pulse_edge", pulse_idx, 6);

      // Release bounce from PRESSED: no new pulse, level stays high.
      window_start();
      hold(1'b0, 2);
      hold(1'b1, 10);
      check_int("relbounce_pulse_count", obs_pulses, 0);
      check_int("relbounce_fall_edge", fall_idx, -1);
      check_bit("relbounce_level", sw_level, 1'b1);

      // Async reset while PRESSED drops sw_level without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      check_bit("async_rst_level", sw_level, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      hold(1'b0, 5);

      // Reset mid-PRESS_CHK (cnt = 2 after E4), sw kept high throughout.
      window_start();
      hold(1'b1, 5);
      #2;
      reset = 1'b0;
      #1;
      check_bit("midrst_x", x, 1'b0);
      check_bit("midrst_level", sw_level, 1'b0);
      check_int("midrst_pulse_count", obs_pulses, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      window_start();
      hold(1'b1, 12);
      check_int("after_rst_pulse_count", obs_pulses, 1);
      check_int("after_rst_pulse_edge", pulse_idx, 6);
      hold(1'b0, 10);

      // Randomized bouncing segments against the model.
      for (int seg = 0; seg < 400; seg++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end
      hold(1'b0, 10);

      // Chain: 12 clean presses into the BCD counter.
      do_reset();
      #1;
      check_int("bcd_start", int'(bcd), 0);
      for (int p = 0; p < 12; p++) begin
         window_start();
         hold(1'b1, 8);
         hold(1'b0, 8);
         check_int("chain_press_pulses", obs_pulses, 1);
         check_int("chain_bcd", int'(bcd), (p + 1) % 10);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_pulse.md
BTN_PULSE -- requirements
Module: btn_pulse

Interface
REQ-001 Parameter DB_CYCLES, default 4, is the debounce stability length N in clock cycles; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; reset==1'b0 forces the reset state immediately, independent of clk.
REQ-004 sw  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-005 x  output  1  registered one-cycle count-enable pulse, one pulse per debounced press; drives the x input of the downstream BCD counter stage.
REQ-006 sw_level  output  1  registered debounced button level; 1 = stably pressed.

Function
REQ-007 sw SHALL pass through a two-flop synchronizer (s1<=sw, s2<=s1); only s2 SHALL feed the FSM.
REQ-008 FSM states SHALL be IDLE, PRESS_CHK, PRESSED, REL_CHK, with a 16-bit stability counter cnt.
REQ-009 IDLE: s2==1 -> PRESS_CHK with cnt<=0; else stay in IDLE.
REQ-010 PRESS_CHK: s2==0 -> IDLE (bounce rejected, no pulse); s2==1 and cnt==N-1 -> PRESSED with x<=1; else cnt<=cnt+1.
REQ-011 PRESSED: s2==0 -> REL_CHK with cnt<=0; else stay in PRESSED.
REQ-012 REL_CHK: s2==1 -> PRESSED (release bounce rejected, no new pulse); s2==0 and cnt==N-1 -> IDLE; else cnt<=cnt+1.
REQ-013 x SHALL be 1 for exactly one cycle, following the PRESS_CHK->PRESSED transition edge; it is 0 in all other cycles.
REQ-014 A continuously held button SHALL produce exactly one pulse; no auto-repeat.
REQ-015 sw_level SHALL be 1 in PRESSED and REL_CHK and 0 in IDLE and PRESS_CHK, registered alongside the state.
REQ-016 Latency: with E0 as the first posedge sampling sw==1 and sw stable thereafter, x SHALL be high in the cycle after edge E(N+2); for N=4, x is high only between E6 and E7.
REQ-017 Release latency: with E0 as the first posedge sampling sw==0 from PRESSED, sw_level SHALL fall after edge E(N+2).
REQ-018 cnt SHALL never exceed N-1; there is no wrap-around path.
REQ-019 A second press SHALL be accepted only after the FSM has returned to IDLE.

Reset
REQ-020 On reset==0: s1=s2=0, state=IDLE, cnt=0, x=0, sw_level=0, asynchronously.
REQ-021 Reset asserted in any state, including mid-PRESS_CHK, SHALL abort with no pulse.
REQ-022 After release of reset with sw already held high, the FSM SHALL treat sw as a new press and emit one pulse per REQ-016.
REQ-023 Reset release SHALL take effect at the first posedge after reset returns to 1.

Verification (N=4)
REQ-024 Clean press: sw 0->1 held 20 cycles -> exactly one x pulse, high between E6 and E7; sw_level 1 from E6.
REQ-025 Bounce: sw toggles 1,0,1,0 every cycle for 6 cycles, then held 1 -> no pulse during bounce; exactly one pulse N+2 edges after the final rise.
REQ-026 Short glitch: sw high for 3 cycles then 0 -> x stays 0 throughout; FSM returns to IDLE; sw_level stays 0.
REQ-027 Release bounce: from PRESSED, sw drops for 2 cycles then returns high -> no new pulse; sw_level stays 1.
REQ-028 Mid-operation reset: reset=0 during PRESS_CHK (cnt=2) -> x=0 and sw_level=0 immediately; after release with sw held high, one pulse 6 edges later.
REQ-029 Chain check: drive x into the BCD counter, apply 12 clean presses -> counter reads 0,1,...,9,0,1, with exactly one increment per press.
